remote_hex_encoder: RTL and testbench

- Player-side encoder for the two-player quiz remote.
- Turns eight raw answer buttons (four per player) into the active-low, one-cold 8-bit joystick code that the game's answer checker consumes.
- Synchronises and debounces the buttons, accepts one press at a time, and emits each accepted press as one fixed-width code pulse.
- Sits between the physical buttons and the `min_hex_joy` input of the game top level.

---
 rtl/remote_hex_encoder.sv | 120 ++++++++++++
 tb/tb_remote_hex_encoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_hex_encoder.sv
// remote_hex_encoder: synchronises and debounces eight answer buttons into a one-cold joystick pulse.
// Optional macro REMOTE_PRIORITY_EN: simultaneous presses resolve to the highest synchronised bit.
module remote_hex_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_p1,
  input  logic [3:0] btn_p2,
  input  logic       enable,
  output logic [7:0] hex_joy,
  output logic       press_valid,
  output logic       busy
);
  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

  state_t        state;
  logic [7:0]    raw;
  logic [7:0]    sync_meta;
  logic [7:0]    sync;
  logic [7:0]    cap;
  logic [7:0]    pick;
  logic [7:0]    cmp;
  logic          pick_ok;
  logic [CW-1:0] cnt;

  // Bit order puts player 1 answer 1 at bit 7, matching the code map directly.
  assign raw = {btn_p1[0], btn_p1[1], btn_p1[2], btn_p1[3],
                btn_p2[0], btn_p2[1], btn_p2[2], btn_p2[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

`ifdef REMOTE_PRIORITY_EN
  always_comb begin
    pick = '0;
    for (int i = 0; i < 8; i++) begin
      if (sync[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end
  assign pick_ok = |sync;
  // Other held buttons must not disturb debouncing of the winner.
  assign cmp     = sync & cap;
`else
  assign pick    = sync;
  assign pick_ok = $onehot(sync);
  assign cmp     = sync;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cap         <= '0;
      hex_joy     <= 8'hFF;
      press_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      press_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && pick_ok) begin
            cap   <= pick;
            cnt   <= '0;
            state <= DEBOUNCE;
            busy  <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (cmp != cap || !enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == DEB_LAST) begin
            state       <= EMIT;
            hex_joy     <= ~cap;
            press_valid <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EMIT: begin
          if (cnt == HOLD_LAST) begin
            hex_joy <= 8'hFF;
            state   <= WAIT_RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (sync == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          hex_joy <= 8'hFF;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_remote_hex_encoder.sv
// Bench for remote_hex_encoder: directed scenarios plus random presses, scoreboard-checked.
`timescale 1ns/1ps
module tb_remote_hex_encoder;
  localparam int D = 16;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_p1 = 4'h0;
  logic [3:0] btn_p2 = 4'h0;
  logic       enable = 1'b1;
  logic [7:0] hex_joy;
  logic       press_valid;
  logic       busy;

  remote_hex_encoder #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .btn_p1(btn_p1), .btn_p2(btn_p2), .enable(enable),
    .hex_joy(hex_joy), .press_valid(press_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] code;
    int         at;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference code: player p (0/1), answer a (0..3) clears bit 7-(4p+a).
  function automatic logic [7:0] code_of(input int p, input int a);
    logic [7:0] msb;
    msb = 8'h80;
    return 8'hFF ^ (msb >> (4 * p + a));
  endfunction

  task automatic expect_press(input logic [7:0] code, input int drive_cyc);
    exp_t e;
    e.code = code;
    e.at   = drive_cyc + D + 3;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int p, input int a, input logic v);
    if (p == 0) btn_p1[a] = v;
    else        btn_p2[a] = v;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    tick(3);
    while (busy && t < 100) begin
      tick(1);
      t++;
    end
    check("idle_reached", busy, 0);
    tick(2);
  endtask

  // Monitor: pops expected codes on press_valid and tracks the hold window.
  initial begin : monitor
    logic [7:0] cur;
    int         hold_left;
    exp_t       e;
    cur = 8'hFF;
    hold_left = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hold_left = 0;
        check("rst_hex_joy", hex_joy, 8'hFF);
        check("rst_press_valid", press_valid, 0);
        check("rst_busy", busy, 0);
      end else begin
        if (press_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_press_valid", 1, 0);
            hold_left = 0;
          end else begin
            e = sb.pop_front();
            $display("press code=%02h expected=%02h cycle=%0d expected_cycle=%0d",
                     hex_joy, e.code, cyc, e.at);
            check("press_code", hex_joy, e.code);
            check("press_cycle", cyc, e.at);
            cur = e.code;
            hold_left = H;
          end
        end
        check("hex_joy_window", hex_joy, (hold_left > 0) ? cur : 8'hFF);
        if (hold_left > 0) hold_left--;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, scoreboard depth %0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int c;
    int p;
    int a;
    int nb;
    int mode;

    // Reset with every button pressed.
    btn_p1 = 4'hF;
    btn_p2 = 4'hF;
    tick(4);
    check("reset_hex_joy", hex_joy, 8'hFF);
    check("reset_busy", busy, 0);
    btn_p1 = 4'h0;
    btn_p2 = 4'h0;
    tick(3);
    rst = 1'b0;
    tick(4);

    // Clean press of player 1 answer 3.
    set_btn(0, 2, 1'b1);
    c = cyc;
    expect_press(code_of(0, 2), c);
    tick(D + H + 6);
    set_btn(0, 2, 1'b0);
    wait_idle();

    // Bouncing player 2 answer 4, then held.
    set_btn(1, 3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(5);
      btn_p2[3] = ~btn_p2[3];
    end
    c = cyc;
    expect_press(code_of(1, 3), c);
    tick(D + H + 6);
    set_btn(1, 3, 1'b0);
    wait_idle();

    // Long hold of player 2 answer 1: one pulse, busy until release + 2.
    set_btn(1, 0, 1'b1);
    c = cyc;
    expect_press(code_of(1, 0), c);
    tick(200);
    check("held_busy_before_release", busy, 1);
    set_btn(1, 0, 1'b0);
    tick(1);
    check("release_busy_1", busy, 1);
    tick(1);
    check("release_busy_2", busy, 1);
    tick(1);
    check("release_busy_3", busy, 0);
    tick(2);

    // Enable dropped mid-debounce: no pulse.
    set_btn(0, 3, 1'b1);
    tick(8);
    check("debounce_busy", busy, 1);
    enable = 1'b0;
    tick(30);
    set_btn(0, 3, 1'b0);
    wait_idle();
    enable = 1'b1;

    // Simultaneous press of player 1 answer 1 and player 2 answer 1.
    btn_p1[0] = 1'b1;
    btn_p2[0] = 1'b1;
    c = cyc;
`ifdef REMOTE_PRIORITY_EN
    expect_press(8'h7F, c);
    tick(8);
    check("simul_busy", busy, 1);
`else
    tick(8);
    check("simul_busy", busy, 0);
`endif
    tick(D + H);
    btn_p1[0] = 1'b0;
    btn_p2[0] = 1'b0;
    wait_idle();

    // Reset on the third EMIT cycle truncates the pulse.
    set_btn(1, 1, 1'b1);
    c = cyc;
    expect_press(code_of(1, 1), c);
    tick(D + 5);
    rst = 1'b1;
    #1;
    check("midemit_hex_joy", hex_joy, 8'hFF);
    check("midemit_busy", busy, 0);
    set_btn(1, 1, 1'b0);
    tick(3);
    rst = 1'b0;
    tick(6);
    check("after_reset_idle", busy, 0);

    // Random single-button presses with bounce, short taps and disabled presses.
    for (int it = 0; it < 40; it++) begin
      p  = int'($urandom_range(0, 1));
      a  = int'($urandom_range(0, 3));
      nb = int'($urandom_range(0, 3));
      for (int b = 0; b < nb; b++) begin
        set_btn(p, a, 1'b1);
        tick(int'($urandom_range(1, 6)));
        set_btn(p, a, 1'b0);
        tick(int'($urandom_range(1, 6)));
      end
      mode = int'($urandom_range(0, 3));
      if (mode == 1) enable = 1'b0;
      set_btn(p, a, 1'b1);
      c = cyc;
      if (mode >= 2) expect_press(code_of(p, a), c);
      if (mode == 0) tick(int'($urandom_range(1, D - 2)));
      else           tick(D + H + int'($urandom_range(2, 10)));
      set_btn(p, a, 1'b0);
      wait_idle();
      enable = 1'b1;
    end

    tick(10);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
